uart_tx_fifo_feeder: RTL and testbench
======================================

UART_TX_FIFO_FEEDER -- requirements
Module: uart_tx_fifo_feeder

Interface
REQ-001 Parameter NUM_OF_DATA_BITS_IN_PACK, default 8, SHALL set the data word width in bits.
REQ-002 Parameter FIFO_DEPTH_LOG2, default 4, SHALL set the FIFO depth to 2**FIFO_DEPTH_LOG2 entries (16).
REQ-003 IN_CLOCK  input  1 SHALL be the single clock; all logic SHALL update on its rising edge.
REQ-004 IN_RESET_N  input  1 SHALL be the reset: asynchronous assert, active-low.
REQ-005 IN_WR_EN  input  1 SHALL be the producer write strobe, sampled each clock.
REQ-006 IN_WR_DATA  input  NUM_OF_DATA_BITS_IN_PACK SHALL be the word written when IN_WR_EN=1.
REQ-007 OUT_FULL / OUT_EMPTY  output  1 each SHALL flag that the FIFO holds 2**FIFO_DEPTH_LOG2 / 0 entries.
REQ-008 OUT_LEVEL  output  FIFO_DEPTH_LOG2+1 SHALL give the current entry count.
REQ-009 OUT_TX_LAUNCH  output  1 SHALL drive IN_TX_LAUNCH of the downstream UART_TX_RX_MODULE.
REQ-010 OUT_TX_DATA  output  NUM_OF_DATA_BITS_IN_PACK SHALL drive IN_TX_DATA of the downstream UART_TX_RX_MODULE.
REQ-011 IN_TX_ACTIVE / IN_TX_DONE  input  1 each SHALL connect to OUT_TX_ACTIVE / OUT_TX_DONE of the UART module.
REQ-012 OUT_BUSY  output  1 SHALL be high whenever the state is not IDLE.

Function
REQ-013 FIFO: circular buffer, write and read pointers of FIFO_DEPTH_LOG2 bits wrapping modulo depth, count register of FIFO_DEPTH_LOG2+1 bits.
REQ-014 Write accepted when IN_WR_EN=1 and (OUT_FULL=0 or a pop occurs in the same cycle); the entry is visible (OUT_EMPTY=0, OUT_LEVEL incremented) on the next cycle.
REQ-015 Write while full without a same-cycle pop SHALL be dropped; FIFO contents, pointers and OUT_LEVEL SHALL remain unchanged.
REQ-016 Simultaneous accepted write and pop SHALL leave OUT_LEVEL unchanged; on an empty FIFO the write is not popped in the same cycle (no fall-through).
REQ-017 FSM states: IDLE, LAUNCH, WAIT_DONE.
REQ-018 IDLE: if OUT_EMPTY=0, pop the head word into the OUT_TX_DATA register, set OUT_TX_LAUNCH=1, go to LAUNCH; otherwise stay, OUT_TX_LAUNCH=0.
REQ-019 LAUNCH: hold OUT_TX_LAUNCH=1 until IN_TX_ACTIVE=1 is sampled, then clear OUT_TX_LAUNCH and go to WAIT_DONE.
REQ-020 WAIT_DONE: OUT_TX_LAUNCH=0; on IN_TX_DONE=1 go to IDLE.
REQ-021 OUT_TX_DATA SHALL stay stable from the pop until the return to IDLE; it holds the last value otherwise.
REQ-022 Latency: word written at cycle N into an empty FIFO with FSM in IDLE -> OUT_TX_LAUNCH=1 at cycle N+2.
REQ-023 Back-to-back: after IN_TX_DONE the next word SHALL be popped no earlier than one cycle in IDLE, giving at least one launch-low cycle between frames.
REQ-024 IN_TX_DONE in IDLE or LAUNCH SHALL be ignored.
REQ-025 Words SHALL be transmitted in strict write order, none duplicated or skipped.

Reset
REQ-026 IN_RESET_N=0 SHALL asynchronously force state IDLE, pointers and count 0, OUT_EMPTY=1, OUT_FULL=0, OUT_LEVEL=0, OUT_TX_LAUNCH=0, OUT_TX_DATA=0, OUT_BUSY=0.
REQ-027 Reset mid-frame SHALL discard all FIFO contents and the in-flight word; no launch SHALL occur until a new write after release.
REQ-028 FIFO storage array SHALL need no reset.

Configuration
REQ-029 Macro UART_TX_FEEDER_OVF_FLAG_EN defined: adds output OUT_OVERFLOW (1 bit, sticky, set the cycle after a dropped write) and input IN_OVERFLOW_CLEAR (1 bit, clears it; a set in the same cycle wins); reset value 0.
REQ-030 Macro undefined: both ports absent, dropped writes silent; all other behaviour identical.

Verification
REQ-031 Reset, write 0x55 once -> OUT_TX_LAUNCH=1 two cycles later with OUT_TX_DATA=0x55, low after IN_TX_ACTIVE, OUT_BUSY=0 after IN_TX_DONE.
REQ-032 Burst-write 0x00,0x40,0x80,0xC0 with UART model -> four frames in that order, launch low at least one cycle between frames, OUT_LEVEL 4->0.
REQ-033 Hold transmitter in WAIT_DONE, write 17 words 0x01..0x11 -> OUT_FULL=1 after the 16th, 0x11 dropped, OUT_LEVEL=16; with macro OUT_OVERFLOW=1 until IN_OVERFLOW_CLEAR.
REQ-034 Full FIFO, write 0xAA in the pop cycle -> write accepted, OUT_LEVEL stays 16, 0xAA transmitted last.
REQ-035 Assert IN_RESET_N=0 during WAIT_DONE with 5 words queued -> all outputs at reset values immediately; no launch after release without new writes.
REQ-036 Loop two feeders through two UART_TX_RX_MODULE instances at 9600 baud, 38400 Hz clock, parity 2 -> every received OUT_RX_DATA equals the written word, OUT_RX_ERROR stays 0.

Source files
------------

// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder: write FIFO of 2**FIFO_DEPTH_LOG2 words that hands one word at a time to a UART transmitter.
// Optional sticky overflow flag (OUT_OVERFLOW / IN_OVERFLOW_CLEAR) is enabled by defining UART_TX_FEEDER_OVF_FLAG_EN.
module uart_tx_fifo_feeder #(
    parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
    parameter int FIFO_DEPTH_LOG2          = 4
) (
    input  logic                                IN_CLOCK,
    input  logic                                IN_RESET_N,
    input  logic                                IN_WR_EN,
    input  logic [NUM_OF_DATA_BITS_IN_PACK-1:0] IN_WR_DATA,
    output logic                                OUT_FULL,
    output logic                                OUT_EMPTY,
    output logic [FIFO_DEPTH_LOG2:0]            OUT_LEVEL,
    output logic                                OUT_TX_LAUNCH,
    output logic [NUM_OF_DATA_BITS_IN_PACK-1:0] OUT_TX_DATA,
    input  logic                                IN_TX_ACTIVE,
    input  logic                                IN_TX_DONE,
    output logic                                OUT_BUSY
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
    ,
    output logic                                OUT_OVERFLOW,
    input  logic                                IN_OVERFLOW_CLEAR
`endif
);

    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_DONE
    } state_t;

    logic [NUM_OF_DATA_BITS_IN_PACK-1:0] mem [DEPTH];

    logic [FIFO_DEPTH_LOG2-1:0]          wr_ptr_reg, wr_ptr_next;
    logic [FIFO_DEPTH_LOG2-1:0]          rd_ptr_reg, rd_ptr_next;
    logic [FIFO_DEPTH_LOG2:0]            count_reg, count_next;
    state_t                              state_reg, state_next;
    logic                                launch_reg, launch_next;
    logic [NUM_OF_DATA_BITS_IN_PACK-1:0] tx_data_reg, tx_data_next;

    logic full;
    logic empty;
    logic pop;
    logic wr_accept;

    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == '0);

    // A pop only happens from IDLE on a non-empty FIFO, so a write into an empty FIFO never falls through.
    assign pop       = (state_reg == ST_IDLE) && !empty;
    assign wr_accept = IN_WR_EN && (!full || pop);

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge IN_CLOCK) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= IN_WR_DATA;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({wr_accept, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        launch_next  = launch_reg;
        tx_data_next = tx_data_reg;
        case (state_reg)
            ST_IDLE: begin
                launch_next = 1'b0;
                if (!empty) begin
                    tx_data_next = mem[rd_ptr_reg];
                    launch_next  = 1'b1;
                    state_next   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                launch_next = 1'b1;
                if (IN_TX_ACTIVE) begin
                    launch_next = 1'b0;
                    state_next  = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                launch_next = 1'b0;
                if (IN_TX_DONE) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                launch_next = 1'b0;
                state_next  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            state_reg   <= ST_IDLE;
            launch_reg  <= 1'b0;
            tx_data_reg <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            state_reg   <= state_next;
            launch_reg  <= launch_next;
            tx_data_reg <= tx_data_next;
        end
    end

`ifdef UART_TX_FEEDER_OVF_FLAG_EN
    logic overflow_reg, overflow_next;
    logic wr_drop;

    assign wr_drop = IN_WR_EN && !wr_accept;

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        overflow_next = overflow_reg;
        if (wr_drop) begin
            overflow_next = 1'b1;
        end else if (IN_OVERFLOW_CLEAR) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= overflow_next;
        end
    end

    assign OUT_OVERFLOW = overflow_reg;
`endif

    assign OUT_FULL      = full;
    assign OUT_EMPTY     = empty;
    assign OUT_LEVEL     = count_reg;
    assign OUT_TX_LAUNCH = launch_reg;
    assign OUT_TX_DATA   = tx_data_reg;
    assign OUT_BUSY      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// tb_uart_tx_fifo_feeder: queue-based reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_uart_tx_fifo_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, launch, busy;
    logic [4:0] level;
    logic [7:0] tx_data;
    logic       tx_active, tx_done;
    logic       ovf_clear = 1'b0;
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
    logic       overflow;
`endif

    logic auto_mode = 1'b0;
    logic man_active = 1'b0, man_done = 1'b0;
    logic r_active = 1'b0, r_done = 1'b0;
    assign tx_active = auto_mode ? r_active : man_active;
    assign tx_done   = auto_mode ? r_done   : man_done;

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo_feeder #(
        .NUM_OF_DATA_BITS_IN_PACK(8),
        .FIFO_DEPTH_LOG2(4)
    ) dut (
        .IN_CLOCK(clk),
        .IN_RESET_N(rst_n),
        .IN_WR_EN(wr_en),
        .IN_WR_DATA(wr_data),
        .OUT_FULL(full),
        .OUT_EMPTY(empty),
        .OUT_LEVEL(level),
        .OUT_TX_LAUNCH(launch),
        .OUT_TX_DATA(tx_data),
        .IN_TX_ACTIVE(tx_active),
        .IN_TX_DONE(tx_done),
        .OUT_BUSY(busy)
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
        ,
        .OUT_OVERFLOW(overflow),
        .IN_OVERFLOW_CLEAR(ovf_clear)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a word queue plus the transmitter phase (0 idle, 1 launching, 2 waiting for done).
    logic [7:0] mq[$];
    int         m_phase = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_ovf = 1'b0;
    bit         m_pop, m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_phase = 0;
            m_data  = 8'h00;
            m_ovf   = 1'b0;
        end else begin
            m_pop = (m_phase == 0) && (mq.size() != 0);
            m_acc = wr_en && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) begin
                m_data  = mq.pop_front();
                m_phase = 1;
            end else if (m_phase == 1 && tx_active) begin
                m_phase = 2;
            end else if (m_phase == 2 && tx_done) begin
                m_phase = 0;
            end
            if (m_acc) mq.push_back(wr_data);
            if (wr_en && !m_acc) m_ovf = 1'b1;
            else if (ovf_clear) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_level",  level,   mq.size());
            check("m_empty",  empty,   mq.size() == 0);
            check("m_full",   full,    mq.size() == DEPTH);
            check("m_launch", launch,  m_phase == 1);
            check("m_busy",   busy,    m_phase != 0);
            check("m_data",   tx_data, m_data);
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
            check("m_ovf",    overflow, m_ovf);
`endif
        end
    end

    // Randomised UART responder: records each launched word, then active for a few cycles, then a done pulse.
    int         r_state = 0;
    int         r_cnt = 0;
    logic [7:0] rx_q[$];

    always begin
        @(posedge clk);
        #1;
        if (!auto_mode || !rst_n) begin
            r_state  = 0;
            r_active = 1'b0;
            r_done   = 1'b0;
        end else begin
            case (r_state)
                0: begin
                    r_done = ($urandom_range(0, 7) == 0);
                    if (launch) begin
                        rx_q.push_back(tx_data);
                        r_cnt   = $urandom_range(0, 2);
                        r_state = 1;
                    end
                end
                1: begin
                    r_done = ($urandom_range(0, 3) == 0);
                    if (r_cnt == 0) begin
                        r_active = 1'b1;
                        r_done   = 1'b0;
                        r_cnt    = $urandom_range(1, 5);
                        r_state  = 2;
                    end else begin
                        r_cnt--;
                    end
                end
                2: begin
                    r_done = 1'b0;
                    if (r_cnt == 0) begin
                        r_active = 1'b0;
                        r_done   = 1'b1;
                        r_state  = 3;
                    end else begin
                        r_cnt--;
                    end
                end
                default: begin
                    r_done  = 1'b0;
                    r_state = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((!empty || busy) && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL %s drain timeout level=%0d busy=%0d required empty and idle", name, level, busy);
        end
    endtask

    task automatic put(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    logic [7:0] burst [4];
    int         rate;

    initial begin
        burst[0] = 8'h00; burst[1] = 8'h40; burst[2] = 8'h80; burst[3] = 8'hC0;

        #2 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        tick();
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_launch", launch, 0);
        check("rst_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single word: launch two cycles after the write, drop on active, idle after done.
        put(8'h55);
        check("w55_launch_n1", launch, 0);
        check("w55_level_n1", level, 1);
        tick();
        check("w55_launch_n2", launch, 1);
        check("w55_data", tx_data, 8'h55);
        check("w55_busy", busy, 1);
        man_active = 1'b1;
        tick();
        check("w55_launch_low", launch, 0);
        check("w55_busy_wait", busy, 1);
        man_active = 1'b0;
        man_done   = 1'b1;
        tick();
        man_done = 1'b0;
        check("w55_busy_done", busy, 0);
        check("w55_data_hold", tx_data, 8'h55);
        tick();

        // Burst of four through the responder.
        rx_q.delete();
        auto_mode = 1'b1;
        for (int i = 0; i < 4; i++) put(burst[i]);
        wait_drain("burst");
        check("burst_count", rx_q.size(), 4);
        for (int i = 0; i < 4 && i < rx_q.size(); i++) check("burst_order", rx_q[i], burst[i]);
        auto_mode = 1'b0;
        tick();

        // Park in WAIT_DONE, then overfill with 0x01..0x11.
        put(8'hEE);
        tick();
        check("park_launch", launch, 1);
        man_active = 1'b1;
        tick();
        check("park_busy", busy, 1);
        for (int i = 1; i <= 17; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            tick();
            if (i == 16) begin
                check("fill16_level", level, 16);
                check("fill16_full", full, 1);
            end
        end
        wr_en = 1'b0;
        check("drop_level", level, 16);
        check("drop_full", full, 1);
`ifdef UART_TX_FEEDER_OVF_FLAG_EN
        check("ovf_set", overflow, 1);
        tick();
        check("ovf_sticky", overflow, 1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("ovf_cleared", overflow, 0);
`endif

        // Write 0xAA in the very cycle the full FIFO pops.
        man_active = 1'b0;
        man_done   = 1'b1;
        tick();
        man_done = 1'b0;
        check("pop_cycle_idle", busy, 0);
        put(8'hAA);
        check("popwr_level", level, 16);
        check("popwr_launch", launch, 1);
        check("popwr_data", tx_data, 8'h01);
        rx_q.delete();
        auto_mode = 1'b1;
        wait_drain("full_drain");
        check("full_count", rx_q.size(), 17);
        if (rx_q.size() == 17) begin
            check("full_first", rx_q[0], 8'h01);
            check("full_16th", rx_q[15], 8'h10);
            check("full_last", rx_q[16], 8'hAA);
        end
        auto_mode = 1'b0;
        tick();

        // Reset while waiting for done with five words queued.
        put(8'h11);
        tick();
        man_active = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) put(8'(8'hA0 + i));
        check("pre_rst_level", level, 5);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_level", level, 0);
        check("async_rst_empty", empty, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_launch", launch, 0);
        check("async_rst_data", tx_data, 8'h00);
        tick();
        tick();
        rst_n      = 1'b1;
        man_active = 1'b0;
        auto_mode  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_no_launch", launch, 0);
        end

        // Randomised traffic at several write rates, rare async resets, random flag clears.
        for (int seg = 0; seg < 6; seg++) begin
            case (seg)
                0: rate = 5;
                1: rate = 30;
                2: rate = 70;
                3: rate = 100;
                4: rate = 50;
                default: rate = 90;
            endcase
            for (int c = 0; c < 500; c++) begin
                wr_en     = ($urandom_range(0, 99) < rate);
                wr_data   = 8'($urandom);
                ovf_clear = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 799) == 0) begin
                    rst_n = 1'b0;
                    tick();
                    rst_n = 1'b1;
                end else begin
                    tick();
                end
            end
            wr_en     = 1'b0;
            ovf_clear = 1'b0;
            wait_drain("random_drain");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
